// File: rtl/bcd_arb_pkg.sv
// Shared types for the two-requester BCD conversion arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_arb_pkg;

  // Number of requesters sharing the converter.
  localparam int unsigned NUM_REQ = 2;

  // Single-entry response holding register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/binary_to_bcd_5b.sv
// Combinational 5-bit binary to two-digit BCD converter (0..31 -> tens 0..3, ones 0..9).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: bin_i (5-bit binary), tens_o (BCD tens, [3:2] tied low), ones_o (BCD ones).
module binary_to_bcd_5b (
  input  logic [4:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [1:0] tens_lo;
  logic [4:0] rem;

  // Range compare instead of divide: only four possible tens values.
  always_comb begin
    tens_lo = 2'd0;
    rem     = bin_i;
    if (bin_i >= 5'd30) begin
      tens_lo = 2'd3;
      rem     = bin_i - 5'd30;
    end else if (bin_i >= 5'd20) begin
      tens_lo = 2'd2;
      rem     = bin_i - 5'd20;
    end else if (bin_i >= 5'd10) begin
      tens_lo = 2'd1;
      rem     = bin_i - 5'd10;
    end
  end

  // Upper tens bits are structurally zero so they stay clean even for unknown inputs.
  assign tens_o = {2'b00, tens_lo};
  assign ones_o = rem[3:0];

endmodule

// File: rtl/bcd_conv_arb.sv
// Round-robin arbiter sharing one binary-to-BCD converter between two requesters.
// Latency: response registered 1 cycle after the request handshake; 1 conversion/cycle sustained.
// Backpressure: a held response with resp_rdy=0 blocks all grants; reqN_rdy drops until dequeue.
// Ports: clk/rst (sync active-high), req0_*/req1_* val/rdy/in handshakes,
//        resp_val/resp_rdy handshake with resp_id, resp_tens, resp_ones.
module bcd_conv_arb
  import bcd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_val,
  output logic       req0_rdy,
  input  logic [4:0] req0_in,
  input  logic       req1_val,
  output logic       req1_rdy,
  input  logic [4:0] req1_in,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic       resp_id,
  output logic [3:0] resp_tens,
  output logic [3:0] resp_ones
);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       id_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;

  logic       out_free;
  logic       gnt_vld;
  logic       gnt_id;
  logic [4:0] cnv_in;
  logic [3:0] cnv_tens;
  logic [3:0] cnv_ones;

  // Grant, handshake and next-state logic.
  always_comb begin
    out_free = (state_q == EMPTY) || resp_rdy;
    gnt_vld  = 1'b0;
    gnt_id   = ptr_q;
    state_d  = state_q;
    ptr_d    = ptr_q;

    if (!rst && out_free) begin
      if (req0_val && req1_val) begin
        gnt_vld = 1'b1;
        gnt_id  = ptr_q;
      end else if (req0_val) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_val) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end

    if (gnt_vld) begin
      ptr_d = ~gnt_id;
    end

    case (state_q)
      EMPTY: if (gnt_vld) state_d = FULL;
      FULL:  if (resp_rdy && !gnt_vld) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign req0_rdy = gnt_vld && !gnt_id;
  assign req1_rdy = gnt_vld && gnt_id;

  // Only the granted requester's value reaches the converter.
  assign cnv_in = gnt_id ? req1_in : req0_in;

  binary_to_bcd_5b u_cnv (
    .bin_i  (cnv_in),
    .tens_o (cnv_tens),
    .ones_o (cnv_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // Loading only on grant keeps contents stable while stalled.
      if (gnt_vld) begin
        id_q   <= gnt_id;
        tens_q <= cnv_tens;
        ones_q <= cnv_ones;
      end
    end
  end

  // Valid is masked during reset so a held entry is never presented once reset is seen.
  assign resp_val  = (state_q == FULL) && !rst;
  assign resp_id   = id_q;
  assign resp_tens = tens_q;
  assign resp_ones = ones_q;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Scoreboard bench for bcd_conv_arb: directed stimulus, queued expectations, monitor on negedge.
module tb_bcd_conv_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_val = 1'b0;
  logic       req0_rdy;
  logic [4:0] req0_in = 5'd0;
  logic       req1_val = 1'b0;
  logic       req1_rdy;
  logic [4:0] req1_in = 5'd0;
  logic       resp_val;
  logic       resp_rdy = 1'b1;
  logic       resp_id;
  logic [3:0] resp_tens;
  logic [3:0] resp_ones;

  always #5 clk = ~clk;

  bcd_conv_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_in   (req0_in),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_in   (req1_in),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_id   (resp_id),
    .resp_tens (resp_tens),
    .resp_ones (resp_ones)
  );

  typedef struct packed {
    logic       id;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       xchk;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state.
  bit armed    = 1'b0;
  bit m_full   = 1'b0;
  bit m_ptr    = 1'b0;
  bit zero_chk = 1'b0;
  bit x_mode   = 1'b0;
  // Snapshot taken at negedge, applied at the following posedge.
  bit s_rst = 1'b1;
  bit s_rr  = 1'b0;
  bit s_gv  = 1'b0;
  bit s_gid = 1'b0;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [4:0] v, input bit x);
    exp_t r;
    int   n;
    n      = int'(v);
    r.id   = id;
    r.tens = 4'(n / 10);
    r.ones = 4'(n % 10);
    r.xchk = x;
    return r;
  endfunction

  // Monitor + grant predictor.
  always @(negedge clk) begin
    s_rst = rst;
    s_rr  = resp_rdy;
    s_gv  = 1'b0;
    s_gid = m_ptr;
    if (armed) begin
      check("resp_val", {15'd0, resp_val}, {15'd0, (m_full && !rst)});
      if (zero_chk)
        check("reset_outputs", {7'd0, resp_id, resp_tens, resp_ones}, 16'd0);
      if (resp_val === 1'b1) begin
        if (sb.size() == 0) begin
          check("resp_queue_size", 16'(sb.size()), 16'd1);
        end else begin
          e = sb[0];
          if (e.xchk)
            check("x_resp", {13'd0, resp_id, resp_tens[3:2]}, {13'd0, e.id, 2'b00});
          else
            check("resp_data", {7'd0, resp_id, resp_tens, resp_ones},
                  {7'd0, e.id, e.tens, e.ones});
          if (resp_rdy === 1'b1) void'(sb.pop_front());
        end
      end
      if (!rst && (!m_full || resp_rdy)) begin
        if (req0_val && req1_val) begin
          s_gv = 1'b1; s_gid = m_ptr;
        end else if (req0_val) begin
          s_gv = 1'b1; s_gid = 1'b0;
        end else if (req1_val) begin
          s_gv = 1'b1; s_gid = 1'b1;
        end
      end
      check("req_rdy", {14'd0, req0_rdy, req1_rdy}, {14'd0, (s_gv && !s_gid), (s_gv && s_gid)});
      if (s_gv)
        sb.push_back(mk(s_gid, s_gid ? req1_in : req0_in, (!s_gid) && x_mode));
    end
  end

  always @(posedge clk) begin
    if (s_rst) begin
      armed    = 1'b1;
      m_full   = 1'b0;
      m_ptr    = 1'b0;
      zero_chk = 1'b1;
      sb.delete();
    end else if (armed) begin
      if (s_gv) begin
        m_full   = 1'b1;
        m_ptr    = ~s_gid;
        zero_chk = 1'b0;
      end else if (s_rr) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic drive(input bit r, input bit v0, input logic [4:0] i0,
                       input bit v1, input logic [4:0] i1, input bit rr);
    @(posedge clk);
    #1;
    rst      = r;
    req0_val = v0;
    req0_in  = i0;
    req1_val = v1;
    req1_in  = i1;
    resp_rdy = rr;
    x_mode   = 1'b0;
  endtask

  initial begin
    drive(1, 0, 5'd0, 0, 5'd0, 1);
    // Single request: 17 -> (1,7) id 0.
    drive(0, 1, 5'd17, 0, 5'd0, 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Grant req1 once so the pointer returns to req0.
    drive(0, 0, 5'd0, 1, 5'd25, 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Contention: 31 -> (3,1), 9 -> (0,9), alternating.
    repeat (4) drive(0, 1, 5'd31, 1, 5'd9, 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Backpressure: hold id1 (2,5) for 3 stalled cycles with both requesting.
    drive(0, 0, 5'd0, 1, 5'd25, 0);
    repeat (3) drive(0, 1, 5'd3, 1, 5'd4, 0);
    drive(0, 1, 5'd3, 1, 5'd4, 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Reset mid-operation with (1,0) held.
    drive(0, 1, 5'd10, 0, 5'd0, 0);
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    drive(1, 0, 5'd0, 0, 5'd0, 0);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    repeat (2) drive(0, 1, 5'd7, 1, 5'd8, 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Exhaustive conversion via req1.
    for (int i = 0; i < 32; i++) drive(0, 0, 5'd0, 1, 5'(i), 1);
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    // Unknown input on req0.
    @(posedge clk);
    #1;
    req0_val = 1'b1;
    req0_in  = 5'bxxxxx;
    x_mode   = 1'b1;
    repeat (4) drive(0, 0, 5'd0, 0, 5'd0, 1);
    @(negedge clk);
    #1;
    check("leftover_queue", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arb.md
BCD_CONV_ARB -- requirements
Module: bcd_conv_arb

Interface
REQ-001 SHALL have no parameters; the input width is fixed at 5 bits, and the outputs are tens[3:0] and ones[3:0].
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req0_val  input  1 / req0_rdy  output  1 / req0_in  input  5  requester 0 value handshake.
REQ-005 SHALL have ports req1_val  input  1 / req1_rdy  output  1 / req1_in  input  5  requester 1 value handshake.
REQ-006 SHALL have port resp_val  output  1  response register holds a valid result.
REQ-007 SHALL have port resp_rdy  input  1  consumer accepts the response this cycle.
REQ-008 SHALL have port resp_id  output  1  index of the requester whose value produced the response.
REQ-009 SHALL have ports resp_tens  output  4  and  resp_ones  output  4  BCD digits of the granted value.

Function
REQ-010 SHALL share one combinational 5-bit binary-to-BCD converter between both requesters: tens in 0..3, ones in 0..9, with tens*10+ones equal to the input.
REQ-011 SHALL hold one response entry in an FSM with states EMPTY and FULL.
REQ-012 SHALL treat the output as free in a cycle when the FSM state is EMPTY, or when the state is FULL and resp_rdy=1 (dequeue).
REQ-013 SHALL grant at most one requester per cycle, and only while the output is free and that requester's val=1.
REQ-014 SHALL drive reqN_rdy=1 only for the granted requester; rdy is combinational from state, val, pointer and resp_rdy.
REQ-015 SHALL use round-robin arbitration: a priority pointer selects the preferred requester when both are valid; after a grant to i, the pointer moves to 1-i; with no grant, the pointer is unchanged.
REQ-016 SHALL latch the converted digits and the grant index into the response register on the grant edge, so the response appears exactly 1 cycle after the handshake.
REQ-017 SHALL use the following FSM transitions:
- EMPTY+grant -> FULL
- FULL+dequeue+grant -> FULL (new data)
- FULL+dequeue+no grant -> EMPTY
- FULL+no dequeue -> FULL, with contents held stable
REQ-018 SHALL sustain a throughput of one conversion per cycle while resp_rdy stays high.
REQ-019 SHALL keep resp_val equal to (state==FULL).
REQ-020 SHALL keep resp_tens, resp_ones and resp_id unchanged while resp_val=1 and resp_rdy=0.
REQ-021 SHALL ignore reqN_in whenever the corresponding rdy=0.
REQ-022 SHALL force resp_tens[3:2]=2'b00 at all times, including under X inputs.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set the state to EMPTY, the pointer to requester 0, and resp_tens/resp_ones/resp_id to 0.
REQ-024 SHALL hold req0_rdy=req1_rdy=0 and resp_val=0 while rst=1.
REQ-025 SHALL, when reset is asserted mid-operation, discard any held response without delivering it; the first grant after reset prefers requester 0.

Structure
REQ-026 SHALL place the FSM state enum (EMPTY, FULL) and the requester-count constant (2) in a shared bcd_arb package.
REQ-027 SHALL instantiate exactly one sub-module, binary_to_bcd_5b (combinational converter), fed by a 2:1 mux selected by the grant.
REQ-028 SHALL keep the arbiter pointer, FSM and response register in bcd_conv_arb.

Verification
REQ-029 SHALL cover this single-request scenario: after reset, req0_val=1, req0_in=5'd17, resp_rdy=1 -> req0_rdy=1 that cycle; the next cycle gives resp_val=1, id=0, tens=1, ones=7.
REQ-030 SHALL cover this contention scenario: both val=1 continuously with in0=5'd31 and in1=5'd9, resp_rdy=1 -> responses alternate id 0,1,0,1 with (3,1),(0,9),(3,1),(0,9), one per cycle.
REQ-031 SHALL cover this backpressure scenario: FULL holding id=1 (2,5), resp_rdy=0 for 3 cycles, both val=1 -> both rdy=0 and outputs stable; on resp_rdy=1, the next grant goes per the pointer (req0).
REQ-032 SHALL cover this reset-mid-operation scenario: FULL with (1,0), rst=1 for 1 cycle -> resp_val=0 with outputs 0; a subsequent simultaneous request grants req0 first.
REQ-033 SHALL cover exhaustive conversion: sweep in=0..31 via req1 only -> each response matches tens=in/10 and ones=in%10, with id=1.
REQ-034 SHALL cover X propagation: req0_in=5'bxxxxx granted -> resp_tens=4'b00xx.
